// File: rtl/pid_sched_pkg.sv
// Shared state encodings, fault codes and default timing constants for the
// balance/position control-loop scheduler.
package pid_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_SAMPLE    = 3'd2,
        S_LATCH     = 3'd3,
        S_SETTLE    = 3'd4,
        S_UPDATE    = 3'd5,
        S_FAULT     = 3'd6
    } sched_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_ANGLE    = 2'd1,
        FC_TIMEOUT  = 2'd2,
        FC_OVERRUN  = 2'd3
    } fault_code_t;

    localparam int DEF_TICK_DIV    = 50000;
    localparam int DEF_POS_RATIO   = 5;
    localparam int DEF_SETTLE      = 3;
    localparam int DEF_PWM_MAX     = 7000;
    localparam int DEF_ANGLE_LIMIT = 1000;
    localparam int DEF_ADC_TIMEOUT = 255;

endpackage

// File: rtl/pwm_saturate.sv
// Symmetric signed clamp of the raw motor command to +/-PWM_MAX.
module pwm_saturate #(
    parameter int PWM_MAX = 7000
) (
    input  logic signed [15:0] raw,
    output logic signed [15:0] sat
);

    localparam logic signed [15:0] HI = 16'(PWM_MAX);
    localparam logic signed [15:0] LO = -HI;

    always_comb begin
        sat = raw;
        if (raw > HI)
            sat = HI;
        else if (raw < LO)
            sat = LO;
    end

endmodule

// File: rtl/pid_loop_scheduler.sv
// Sequences one control period: wait for tick, fetch an ADC angle, latch the
// datapath inputs, let the datapath settle, then publish the clamped command.
module pid_loop_scheduler
    import pid_sched_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int POS_RATIO   = DEF_POS_RATIO,
    parameter int SETTLE      = DEF_SETTLE,
    parameter int PWM_MAX     = DEF_PWM_MAX,
    parameter int ANGLE_LIMIT = DEF_ANGLE_LIMIT,
    parameter int ADC_TIMEOUT = DEF_ADC_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               adc_req,
    input  logic               adc_ack,
    input  logic [15:0]        adc_data,
    input  logic [15:0]        enc_count,
    input  logic [15:0]        zhongzhi,
    input  logic signed [15:0] motor_raw,
    output logic [15:0]        sensor_q,
    output logic [15:0]        posi_sensor_q,
    output logic signed [15:0] motor_out,
    output logic               motor_valid,
    output logic               pos_update,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         state
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int PW = $clog2(POS_RATIO + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int AW = $clog2(ADC_TIMEOUT + 1);

    sched_state_t      cur_state, next_state;
    fault_code_t       code, next_code;
    logic [TW-1:0]     tick_cnt;
    logic [PW-1:0]     period_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [AW-1:0]     wait_cnt;
    logic [15:0]       enc_prev;
    logic              running, tick, ang_fault;
    logic signed [16:0] ang_diff, ang_abs;
    logic signed [15:0] motor_sat;

    pwm_saturate #(.PWM_MAX(PWM_MAX)) u_sat (
        .raw (motor_raw),
        .sat (motor_sat)
    );

    assign running   = (cur_state != S_IDLE) && (cur_state != S_FAULT);
    assign tick      = running && (tick_cnt == TW'(TICK_DIV - 1));
    assign ang_diff  = $signed({adc_data[15], adc_data}) - $signed({zhongzhi[15], zhongzhi});
    assign ang_abs   = (ang_diff < 0) ? -ang_diff : ang_diff;
    assign ang_fault = ang_abs > $signed(17'(ANGLE_LIMIT));

    assign adc_req    = (cur_state == S_SAMPLE);
    assign fault      = (cur_state == S_FAULT);
    assign fault_code = code;
    assign state      = cur_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur_state <= S_IDLE;
        else
            cur_state <= next_state;
    end

    // Disable wins over everything outside FAULT; overrun outranks the
    // SAMPLE-local causes, and timeout/angle are mutually exclusive on adc_ack.
    always_comb begin
        next_state = cur_state;
        next_code  = FC_NONE;
        if (running && !enable) begin
            next_state = S_IDLE;
        end else if (tick && cur_state != S_WAIT_TICK) begin
            next_state = S_FAULT;
            next_code  = FC_OVERRUN;
        end else begin
            case (cur_state)
                S_IDLE:      if (enable) next_state = S_WAIT_TICK;
                S_WAIT_TICK: if (tick) next_state = S_SAMPLE;
                S_SAMPLE: begin
                    if (!adc_ack) begin
                        if (wait_cnt == AW'(ADC_TIMEOUT - 1)) begin
                            next_state = S_FAULT;
                            next_code  = FC_TIMEOUT;
                        end
                    end else if (ang_fault) begin
                        next_state = S_FAULT;
                        next_code  = FC_ANGLE;
                    end else begin
                        next_state = S_LATCH;
                    end
                end
                S_LATCH:     next_state = S_SETTLE;
                S_SETTLE:    if (settle_cnt == SW'(SETTLE - 1)) next_state = S_UPDATE;
                S_UPDATE:    next_state = S_WAIT_TICK;
                S_FAULT:     if (!enable) next_state = S_IDLE;
                default:     next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt      <= '0;
            period_cnt    <= '0;
            settle_cnt    <= '0;
            wait_cnt      <= '0;
            enc_prev      <= '0;
            sensor_q      <= '0;
            posi_sensor_q <= '0;
            motor_out     <= '0;
            motor_valid   <= 1'b0;
            pos_update    <= 1'b0;
            code          <= FC_NONE;
        end else begin
            motor_valid <= 1'b0;
            pos_update  <= 1'b0;

            if (!running || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            wait_cnt   <= (cur_state == S_SAMPLE) ? wait_cnt + AW'(1) : '0;
            settle_cnt <= (cur_state == S_SETTLE) ? settle_cnt + SW'(1) : '0;

            if (cur_state == S_IDLE && next_state == S_WAIT_TICK) begin
                enc_prev   <= enc_count;
                period_cnt <= '0;
            end

            // adc_data is only valid with adc_ack, so the latch is taken on
            // that edge and the LATCH cycle presents it to the datapath.
            if (cur_state == S_SAMPLE && next_state == S_LATCH) begin
                sensor_q <= adc_data;
                if (period_cnt == PW'(POS_RATIO - 1)) begin
                    posi_sensor_q <= enc_count - enc_prev;
                    enc_prev      <= enc_count;
                    pos_update    <= 1'b1;
                    period_cnt    <= '0;
                end else begin
                    period_cnt <= period_cnt + PW'(1);
                end
            end

            // Command and its strobe land together for the UPDATE cycle.
            if (cur_state == S_SETTLE && next_state == S_UPDATE) begin
                motor_out   <= motor_sat;
                motor_valid <= 1'b1;
            end else if (next_state == S_IDLE || next_state == S_FAULT) begin
                motor_out <= '0;
            end

            if (next_state == S_FAULT && cur_state != S_FAULT)
                code <= next_code;
            else if (next_state == S_IDLE)
                code <= FC_NONE;
        end
    end

endmodule

// File: tb/tb_pid_loop_scheduler.sv
// Randomized transaction-level check of the loop scheduler against a
// per-period reference model (latency, cadence, clamp, position deltas, faults).
module tb_pid_loop_scheduler;

    localparam int TICK_DIV    = 20;
    localparam int POS_RATIO   = 2;
    localparam int SETTLE      = 3;
    localparam int PWM_MAX     = 100;
    localparam int ANGLE_LIMIT = 50;
    localparam int ADC_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst, en_a, en_b, adc_ack;
    logic [15:0] adc_data, enc_count, zhongzhi;
    logic signed [15:0] motor_raw;

    logic req_a, mv_a, pu_a, flt_a;
    logic [15:0] sq_a, psq_a;
    logic signed [15:0] mo_a;
    logic [1:0] fc_a;
    logic [2:0] st_a;

    logic req_b, mv_b, pu_b, flt_b;
    logic [15:0] sq_b, psq_b;
    logic signed [15:0] mo_b;
    logic [1:0] fc_b;
    logic [2:0] st_b;

    int errors = 0, checks = 0, cyc = 0, last_req = 0;
    bit first;
    int m_prev, m_period;
    logic [15:0] m_posi;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pid_loop_scheduler #(
        .TICK_DIV(TICK_DIV), .POS_RATIO(POS_RATIO), .SETTLE(SETTLE),
        .PWM_MAX(PWM_MAX), .ANGLE_LIMIT(ANGLE_LIMIT), .ADC_TIMEOUT(ADC_TIMEOUT)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(en_a), .adc_req(req_a), .adc_ack(adc_ack),
        .adc_data(adc_data), .enc_count(enc_count), .zhongzhi(zhongzhi),
        .motor_raw(motor_raw), .sensor_q(sq_a), .posi_sensor_q(psq_a),
        .motor_out(mo_a), .motor_valid(mv_a), .pos_update(pu_a), .fault(flt_a),
        .fault_code(fc_a), .state(st_a)
    );

    // Long ADC timeout so the period tick is the first fault to fire.
    pid_loop_scheduler #(
        .TICK_DIV(TICK_DIV), .POS_RATIO(POS_RATIO), .SETTLE(SETTLE),
        .PWM_MAX(PWM_MAX), .ANGLE_LIMIT(ANGLE_LIMIT), .ADC_TIMEOUT(32)
    ) u_ovr (
        .clk(clk), .rst(rst), .enable(en_b), .adc_req(req_b), .adc_ack(adc_ack),
        .adc_data(adc_data), .enc_count(enc_count), .zhongzhi(zhongzhi),
        .motor_raw(motor_raw), .sensor_q(sq_b), .posi_sensor_q(psq_b),
        .motor_out(mo_b), .motor_valid(mv_b), .pos_update(pu_b), .fault(flt_b),
        .fault_code(fc_b), .state(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int clamp(input int v);
        if (v > PWM_MAX) return PWM_MAX;
        if (v < -PWM_MAX) return -PWM_MAX;
        return v;
    endfunction

    task automatic start_run();
        en_a = 1'b1;
        step();
        m_prev   = int'(enc_count);
        m_period = 0;
        first    = 1'b1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 45 && !req_a; i++) step();
        chk("req_seen", 32'(req_a), 32'd1);
    endtask

    // One control period: ack after d cycles with zhongzhi+off, given encoder and raw command.
    task automatic do_period(input int d, input int off, input logic [15:0] enc, input int raw);
        logic [15:0] data;
        data = 16'(int'(zhongzhi) + off);
        wait_req();
        if (!first) chk("period", 32'(cyc - last_req), 32'(TICK_DIV));
        first    = 1'b0;
        last_req = cyc;
        step(d);
        chk("req_hold", 32'(req_a), 32'd1);
        adc_ack   = 1'b1;
        adc_data  = data;
        enc_count = enc;
        motor_raw = 16'(raw);
        step();
        adc_ack  = 1'b0;
        adc_data = 16'($urandom);
        if (off > ANGLE_LIMIT || off < -ANGLE_LIMIT) begin
            chk("ang_fault", 32'(flt_a), 32'd1);
            chk("ang_code", 32'(fc_a), 32'd1);
            chk("ang_motor", 32'(mo_a), 32'd0);
            en_a = 1'b0;
            step();
            chk("ang_exit_state", 32'(st_a), 32'd0);
            chk("ang_exit_fault", 32'(flt_a), 32'd0);
            chk("ang_exit_code", 32'(fc_a), 32'd0);
            start_run();
            return;
        end
        chk("req_drop", 32'(req_a), 32'd0);
        chk("sensor_q", 32'(sq_a), 32'(data));
        if (m_period == POS_RATIO - 1) begin
            m_posi   = enc - 16'(m_prev);
            m_prev   = int'(enc);
            m_period = 0;
            chk("pos_update", 32'(pu_a), 32'd1);
        end else begin
            m_period++;
            chk("pos_update", 32'(pu_a), 32'd0);
        end
        chk("posi_sensor_q", 32'(psq_a), 32'(m_posi));
        for (int k = 2; k <= SETTLE + 2; k++) begin
            step();
            chk("motor_valid", 32'(mv_a), (k == SETTLE + 2) ? 32'd1 : 32'd0);
        end
        chk("motor_out", 32'(mo_a), 32'(clamp(raw)));
        step();
        chk("motor_valid_end", 32'(mv_a), 32'd0);
    endtask

    initial begin
        int n;
        logic [15:0] encs [6];
        int raws [6];
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; adc_ack = 1'b0;
        adc_data = '0; enc_count = 16'd10; zhongzhi = 16'h01F0; motor_raw = '0;
        m_posi = '0; first = 1'b1; m_prev = 0; m_period = 0;
        step(3);
        chk("rst_state", 32'(st_a), 32'd0);
        chk("rst_req", 32'(req_a), 32'd0);
        chk("rst_motor", 32'(mo_a), 32'd0);
        chk("rst_mv", 32'(mv_a), 32'd0);
        chk("rst_pu", 32'(pu_a), 32'd0);
        chk("rst_fault", 32'(flt_a), 32'd0);
        chk("rst_code", 32'(fc_a), 32'd0);
        chk("rst_sensor", 32'(sq_a), 32'd0);
        chk("rst_posi", 32'(psq_a), 32'd0);
        rst = 1'b0;
        step();

        // Nominal, position cadence with 16-bit wrap, saturation.
        encs = '{16'd10, 16'd25, 16'd40, 16'd65535, 16'd100, 16'd3};
        raws = '{40, 40, 40, 300, -300, -100};
        start_run();
        for (int i = 0; i < 6; i++) do_period(2, 16, encs[i], raws[i]);
        do_period(1, ANGLE_LIMIT, 16'd500, 100);
        do_period(3, -ANGLE_LIMIT, 16'd600, -101);

        for (int i = 0; i < 40; i++)
            do_period($urandom_range(0, 6), $urandom_range(0, 120) - 60,
                      16'($urandom), $urandom_range(0, 600) - 300);

        do_period(2, ANGLE_LIMIT + 1, 16'd700, 10);
        do_period(2, 0, 16'd710, 10);

        // ADC timeout.
        wait_req();
        n = 0;
        for (int i = 0; i < 20 && !flt_a; i++) begin
            if (req_a) n++;
            step();
        end
        chk("to_cycles", 32'(n), 32'(ADC_TIMEOUT));
        chk("to_fault", 32'(flt_a), 32'd1);
        chk("to_code", 32'(fc_a), 32'd2);
        chk("to_motor", 32'(mo_a), 32'd0);
        chk("to_req", 32'(req_a), 32'd0);
        en_a = 1'b0;
        step();
        chk("to_exit_state", 32'(st_a), 32'd0);
        chk("to_exit_fault", 32'(flt_a), 32'd0);

        // Overrun: ack withheld past the next tick on the long-timeout instance.
        en_b = 1'b1;
        for (int i = 0; i < 45 && !req_b; i++) step();
        chk("ovr_req_seen", 32'(req_b), 32'd1);
        n = 0;
        for (int i = 0; i < 40 && !flt_b; i++) begin
            if (req_b) n++;
            step();
        end
        chk("ovr_cycles", 32'(n), 32'(TICK_DIV));
        chk("ovr_code", 32'(fc_b), 32'd3);
        chk("ovr_motor", 32'(mo_b), 32'd0);
        en_b = 1'b0;
        step();
        chk("ovr_exit_state", 32'(st_b), 32'd0);
        chk("ovr_exit_code", 32'(fc_b), 32'd0);

        // Reset during SAMPLE, then a stray ack.
        start_run();
        wait_req();
        step();
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(st_a), 32'd0);
        chk("arst_req", 32'(req_a), 32'd0);
        chk("arst_sensor", 32'(sq_a), 32'd0);
        chk("arst_posi", 32'(psq_a), 32'd0);
        chk("arst_motor", 32'(mo_a), 32'd0);
        en_a = 1'b0;
        step();
        rst = 1'b0;
        adc_ack = 1'b1;
        adc_data = 16'h0123;
        step();
        adc_ack = 1'b0;
        chk("stray_state", 32'(st_a), 32'd0);
        chk("stray_sensor", 32'(sq_a), 32'd0);
        chk("stray_req", 32'(req_a), 32'd0);
        step(8);
        chk("stray_idle", 32'(st_a), 32'd0);
        chk("stray_mv", 32'(mv_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
